// File: rtl/clkgen_rst_seq.sv
// Power-up / lock-loss reset sequencer: pulses DCM/PLL reset, waits for stable lock, then DDR2 calibration.
// Latency: async inputs see 2 sync flops, then 1 registered FSM cycle; all outputs change with state_o.
// Backpressure: none; free-running sequencer, retries bounded by MAX_RETRIES, then parks in S_FAIL.
module clkgen_rst_seq #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 65535,
  parameter int STABLE_CYCLES    = 256,
  parameter int CALIB_TIMEOUT    = 1048575,
  parameter int MAX_RETRIES      = 3,
  parameter int CNT_W            = 20
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       dcm_locked_i,
  input  logic       pll_locked_i,
  input  logic       ddr2_calib_done_i,
  output logic       pll_rst_o,
  output logic       ddr2_rst_o,
  output logic       wb_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_PULSE  = 3'd0,
    S_LOCK   = 3'd1,
    S_STABLE = 3'd2,
    S_CALIB  = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  // Largest value the shared counter can represent; every timeout must fit below it.
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Elaboration-time sanity checks on the parameter set.
  if (RST_PULSE_CYCLES < 1) begin : g_bad_pulse
    $fatal(1, "clkgen_rst_seq: RST_PULSE_CYCLES must be at least 1");
  end
  if (LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || CALIB_TIMEOUT < 1) begin : g_bad_timeout
    $fatal(1, "clkgen_rst_seq: timeouts and STABLE_CYCLES must be at least 1");
  end
  if (longint'(RST_PULSE_CYCLES) > CNT_MAX || longint'(LOCK_TIMEOUT) > CNT_MAX ||
      longint'(STABLE_CYCLES) > CNT_MAX || longint'(CALIB_TIMEOUT) > CNT_MAX) begin : g_bad_cnt_w
    $fatal(1, "clkgen_rst_seq: CNT_W too narrow for the configured cycle counts");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_retries
    $fatal(1, "clkgen_rst_seq: MAX_RETRIES must fit in the 4-bit retry counter");
  end

  // Terminal counter values: the counter holds cycles already spent in the state, so
  // the transition happens when it reads N-1 (the Nth cycle in the state).
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  logic [1:0]       dcm_sync;
  logic [1:0]       pll_sync;
  logic [1:0]       calib_sync;
  logic             lock;
  logic             calib_done;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;
  logic             retry_req;

  // Two-flop synchronizers for the asynchronous lock and calibration status inputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dcm_sync   <= 2'b00;
      pll_sync   <= 2'b00;
      calib_sync <= 2'b00;
    end else begin
      dcm_sync   <= {dcm_sync[0], dcm_locked_i};
      pll_sync   <= {pll_sync[0], pll_locked_i};
      calib_sync <= {calib_sync[0], ddr2_calib_done_i};
    end
  end

  // Lock only counts when both clock generators report it.
  assign lock       = dcm_sync[1] & pll_sync[1];
  assign calib_done = calib_sync[1];

  // Next-state, retry bookkeeping and counter update.
  always_comb begin
    state_nxt = state;
    retry_req = 1'b0;
    retry_nxt = retry_cnt_o;
    cnt_nxt   = cnt;

    case (state)
      S_PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        // A lock arriving on the timeout cycle still counts as success.
        if (lock) begin
          state_nxt = S_STABLE;
        end else if (cnt == LOCK_LAST) begin
          retry_req = 1'b1;
        end
      end
      S_STABLE: begin
        // A glitch just restarts the lock wait; it is not a failed attempt.
        if (!lock) begin
          state_nxt = S_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_CALIB;
        end
      end
      S_CALIB: begin
        // Losing lock invalidates any calibration result, so it is checked first.
        if (!lock) begin
          retry_req = 1'b1;
        end else if (calib_done) begin
          state_nxt = S_RUN;
        end else if (cnt == CALIB_LAST) begin
          retry_req = 1'b1;
        end
      end
      S_RUN: begin
        // Calibration dropping while running is deliberately ignored.
        if (!lock) begin
          state_nxt = S_PULSE;
        end
      end
      S_FAIL: begin
        state_nxt = S_FAIL;
      end
      default: begin
        state_nxt = S_PULSE;
      end
    endcase

    if (retry_req) begin
      if (retry_cnt_o == RETRY_MAX) begin
        state_nxt = S_FAIL;
      end else begin
        retry_nxt = retry_cnt_o + 4'd1;
        state_nxt = S_PULSE;
      end
    end

    // A successful bring-up forgets earlier failed attempts.
    if (state_nxt == S_RUN) begin
      retry_nxt = 4'd0;
    end

    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_SAT) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Sequencer FSM; outputs are decoded from the next state so they move with state_o.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_PULSE;
      cnt         <= '0;
      retry_cnt_o <= 4'd0;
      pll_rst_o   <= 1'b1;
      ddr2_rst_o  <= 1'b1;
      wb_rst_o    <= 1'b1;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_cnt_o <= retry_nxt;
      pll_rst_o   <= (state_nxt == S_PULSE);
      ddr2_rst_o  <= (state_nxt inside {S_PULSE, S_LOCK, S_STABLE, S_FAIL});
      wb_rst_o    <= (state_nxt != S_RUN);
      ready_o     <= (state_nxt == S_RUN);
      fail_o      <= (state_nxt == S_FAIL);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_clkgen_rst_seq.sv
// Randomized and directed bench for clkgen_rst_seq against a timestamp-based reference model.
// Latency: expected outputs are queued one edge ahead and checked 1 time unit after each edge.
// Backpressure: none; the monitor consumes one expected vector per clock.
module tb_clkgen_rst_seq;

  localparam int PULSE  = 4;
  localparam int LK_TO  = 32;
  localparam int STABLE = 8;
  localparam int CAL_TO = 64;
  localparam int MAXR   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dcm = 1'b0;
  logic       pll = 1'b0;
  logic       calib = 1'b0;
  logic       pll_rst_o;
  logic       ddr2_rst_o;
  logic       wb_rst_o;
  logic       ready_o;
  logic       fail_o;
  logic [3:0] retry_cnt_o;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  clkgen_rst_seq #(
    .RST_PULSE_CYCLES(PULSE),
    .LOCK_TIMEOUT(LK_TO),
    .STABLE_CYCLES(STABLE),
    .CALIB_TIMEOUT(CAL_TO),
    .MAX_RETRIES(MAXR),
    .CNT_W(20)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .dcm_locked_i(dcm),
    .pll_locked_i(pll),
    .ddr2_calib_done_i(calib),
    .pll_rst_o(pll_rst_o),
    .ddr2_rst_o(ddr2_rst_o),
    .wb_rst_o(wb_rst_o),
    .ready_o(ready_o),
    .fail_o(fail_o),
    .retry_cnt_o(retry_cnt_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase name, the edge it was entered on, and the retry tally.
  // Inputs become visible to the sequencer two edges after they are sampled.
  int   edge_no = 0;
  int   ph = 0;
  int   ph_entry = 0;
  int   m_retry = 0;
  bit   lock_hist[$];
  bit   cal_hist[$];
  logic [11:0] exp_q[$];

  function automatic logic [11:0] expect_vec(int p, int r);
    logic reset_pll;
    logic reset_ddr;
    reset_pll = (p == 0);
    reset_ddr = (p == 0) || (p == 1) || (p == 2) || (p == 5);
    return {reset_pll, reset_ddr, (p != 4), (p == 4), (p == 5), 4'(r), 3'(p)};
  endfunction

  task automatic model_edge();
    bit lk;
    bit cd;
    bit retry;
    int t;
    int nxt;
    edge_no++;
    if (rst) begin
      ph = 0;
      ph_entry = edge_no;
      m_retry = 0;
      lock_hist = '{1'b0, 1'b0};
      cal_hist = '{1'b0, 1'b0};
    end else begin
      lk = lock_hist.pop_front();
      cd = cal_hist.pop_front();
      lock_hist.push_back(dcm && pll);
      cal_hist.push_back(calib);
      t = edge_no - ph_entry;
      nxt = ph;
      retry = 1'b0;
      case (ph)
        0: if (t == PULSE) nxt = 1;
        1: if (lk) nxt = 2; else if (t == LK_TO) retry = 1'b1;
        2: if (!lk) nxt = 1; else if (t == STABLE) nxt = 3;
        3: if (!lk) retry = 1'b1; else if (cd) nxt = 4; else if (t == CAL_TO) retry = 1'b1;
        4: if (!lk) nxt = 0;
        default: nxt = ph;
      endcase
      if (retry) begin
        if (m_retry == MAXR) nxt = 5;
        else begin
          m_retry++;
          nxt = 0;
        end
      end
      if (nxt == 4) m_retry = 0;
      if (nxt != ph) begin
        ph = nxt;
        ph_entry = edge_no;
      end
    end
    exp_q.push_back(expect_vec(ph, m_retry));
  endtask

  // One clock: predict the result of the coming edge from the current inputs, then advance.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Monitor: every edge the DUT presents a full output vector; compare with the scoreboard.
  initial begin
    logic [11:0] got;
    logic [11:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {pll_rst_o, ddr2_rst_o, wb_rst_o, ready_o, fail_o, retry_cnt_o, state_o};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL scoreboard edge=%0d got=%h exp=%h", edge_no, got, exp);
        end
      end
    end
  end

  initial begin
    // Scenario 1: clean bring-up with everything already locked and calibrated.
    rst = 1'b1; dcm = 1'b1; pll = 1'b1; calib = 1'b1;
    repeat (3) cycle();
    chk("reset_state", int'(state_o), 0);
    chk("reset_pll_rst", int'(pll_rst_o), 1);
    chk("reset_wb_rst", int'(wb_rst_o), 1);
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (c == 3) chk("s1_pll_hi_c3", int'(pll_rst_o), 1);
      if (c == 4) chk("s1_pll_lo_c4", int'(pll_rst_o), 0);
      if (c == 12) chk("s1_ddr2_hi_c12", int'(ddr2_rst_o), 1);
      if (c == 13) begin
        chk("s1_ddr2_lo_c13", int'(ddr2_rst_o), 0);
        chk("s1_wb_hi_c13", int'(wb_rst_o), 1);
      end
      if (c == 14) begin
        chk("s1_wb_lo_c14", int'(wb_rst_o), 0);
        chk("s1_ready_c14", int'(ready_o), 1);
        chk("s1_retry_c14", int'(retry_cnt_o), 0);
      end
    end

    // Scenario 2: locks never arrive; retries run out and the sequencer parks in S_FAIL.
    rst = 1'b1; dcm = 1'b0; pll = 1'b0; calib = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      cycle();
      if (c == 35) chk("s2_lock_c35", int'(state_o), 1);
      if (c == 36) begin
        chk("s2_retry1", int'(retry_cnt_o), 1);
        chk("s2_pulse2", int'(pll_rst_o), 1);
      end
      if (c == 72) chk("s2_retry2", int'(retry_cnt_o), 2);
      if (c == 107) chk("s2_not_fail_c107", int'(fail_o), 0);
      if (c == 108) begin
        chk("s2_fail", int'(fail_o), 1);
        chk("s2_state5", int'(state_o), 5);
        chk("s2_pll_lo", int'(pll_rst_o), 0);
        chk("s2_wb_hi", int'(wb_rst_o), 1);
      end
      if (c == 130) chk("s2_fail_held", int'(fail_o), 1);
    end

    // Scenario 3: one-cycle PLL glitch during S_STABLE, then scenario 4: calibration timeout.
    rst = 1'b1; dcm = 1'b1; pll = 1'b1; calib = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      cycle();
      if (c == 9) pll = 1'b0;
      if (c == 10) pll = 1'b1;
      if (c == 11) chk("s3_stable_c11", int'(state_o), 2);
      if (c == 12) begin
        chk("s3_back_to_lock", int'(state_o), 1);
        chk("s3_ddr2_hi", int'(ddr2_rst_o), 1);
        chk("s3_retry0", int'(retry_cnt_o), 0);
      end
      if (c == 20) chk("s3_stable_full", int'(state_o), 2);
      if (c == 21) chk("s3_calib_c21", int'(state_o), 3);
      if (c == 84) chk("s4_calib_ddr2_lo", int'(ddr2_rst_o), 0);
      if (c == 85) begin
        chk("s4_timeout_ddr2_hi", int'(ddr2_rst_o), 1);
        chk("s4_retry1", int'(retry_cnt_o), 1);
      end
      if (c == 86) calib = 1'b1;
      if (c == 99) begin
        chk("s4_ready", int'(ready_o), 1);
        chk("s4_retry_clear", int'(retry_cnt_o), 0);
      end
    end

    // Scenario 5: DCM lock lost while running.
    dcm = 1'b0;
    for (int d = 1; d <= 30; d++) begin
      cycle();
      if (d == 2) chk("s5_wb_still_lo", int'(wb_rst_o), 0);
      if (d == 3) begin
        chk("s5_wb_hi", int'(wb_rst_o), 1);
        chk("s5_ddr2_hi", int'(ddr2_rst_o), 1);
        chk("s5_ready_lo", int'(ready_o), 0);
        chk("s5_retry_kept", int'(retry_cnt_o), 0);
        dcm = 1'b1;
      end
      if (d == 17) chk("s5_ready_again", int'(ready_o), 1);
    end

    // Scenario 6: synchronous reset pulse while in S_CALIB.
    rst = 1'b1; calib = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (15) cycle();
    chk("s6_in_calib", int'(state_o), 3);
    rst = 1'b1;
    cycle();
    chk("s6_state0", int'(state_o), 0);
    chk("s6_ddr2_hi", int'(ddr2_rst_o), 1);
    rst = 1'b0; calib = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (c == 14) chk("s6_ready_c14", int'(ready_o), 1);
    end

    // Random soak: locks mostly held with occasional drops, calibration toggling, rare resets.
    for (int i = 0; i < 4000; i++) begin
      if (dcm) begin if ($urandom_range(59) == 0) dcm = 1'b0; end
      else if ($urandom_range(7) == 0) dcm = 1'b1;
      if (pll) begin if ($urandom_range(59) == 0) pll = 1'b0; end
      else if ($urandom_range(7) == 0) pll = 1'b1;
      if ($urandom_range(29) == 0) calib = ~calib;
      rst = ($urandom_range(399) == 0);
      cycle();
    end
    rst = 1'b0;
    repeat (3) cycle();

    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkgen_rst_seq.md
Name: clkgen_rst_seq

Overview:
- Power-up and lock-loss sequencer for the clock/reset unit.
- Pulses the DCM/PLL reset, waits for both to lock and stay locked, then releases the DDR2 interface reset.
- Waits for DDR2 calibration, then releases the Wishbone reset.
- Retries bounded times on timeout and reports failure.
- Runs on a free-running clock (buffered board oscillator, not a PLL output).

Parameters:
- RST_PULSE_CYCLES, 16: width of the DCM/PLL reset pulse, in cycles (≥1).
- LOCK_TIMEOUT, 65535: cycles allowed in S_LOCK before a retry.
- STABLE_CYCLES, 256: consecutive cycles both locks must stay high.
- CALIB_TIMEOUT, 1048575: cycles allowed for DDR2 calibration.
- MAX_RETRIES, 3: retries before entering S_FAIL.
- CNT_W, 20: width of the shared cycle counter; must hold every count above.

Ports:
- wb_clk_i, in, 1: free-running sequencer clock.
- wb_rst_i, in, 1: synchronous, active-high reset.
- dcm_locked_i, in, 1: DCM lock, asynchronous.
- pll_locked_i, in, 1: PLL lock, asynchronous.
- ddr2_calib_done_i, in, 1: DDR2 calibration complete, asynchronous.
- pll_rst_o, out, 1: reset to DCM and PLL.
- ddr2_rst_o, out, 1: DDR2 interface reset.
- wb_rst_o, out, 1: Wishbone domain reset (pre-synchronizer).
- ready_o, out, 1: sequence complete, system running.
- fail_o, out, 1: retries exhausted.
- retry_cnt_o, out, 4: retries used in the current bring-up.
- state_o, out, 3: current FSM state encoding.

Behaviour:
- Reset is synchronous and active-high on wb_clk_i; one clock domain only.
- Input synchronization: dcm_locked_i, pll_locked_i and ddr2_calib_done_i each pass through 2-flop synchronizers (2-cycle latency). `lock` means both synchronized locks are high.
- Reset values: state=S_PULSE, counter=0, pll_rst_o=1, ddr2_rst_o=1, wb_rst_o=1, ready_o=0, fail_o=0, retry_cnt_o=0.
- wb_rst_i asserted mid-operation forces these values on the next edge.
- States (encoding): S_PULSE=0, S_LOCK=1, S_STABLE=2, S_CALIB=3, S_RUN=4, S_FAIL=5.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as state_o:
  - pll_rst_o=1 only in S_PULSE.
  - ddr2_rst_o=1 in S_PULSE, S_LOCK, S_STABLE and S_FAIL.
  - wb_rst_o=0 only in S_RUN.
  - ready_o=1 only in S_RUN.
  - fail_o=1 only in S_FAIL.
- Counter is cleared on every state change.
- S_PULSE: stays exactly RST_PULSE_CYCLES cycles, then goes to S_LOCK.
- S_LOCK:
  - lock → S_STABLE.
  - Otherwise, when counter=LOCK_TIMEOUT-1, take the retry path.
- S_STABLE:
  - lock held for STABLE_CYCLES consecutive cycles → S_CALIB.
  - Any drop of lock → S_LOCK. The lock timeout restarts; no retry is counted.
- S_CALIB:
  - Synchronized calib_done → S_RUN.
  - counter=CALIB_TIMEOUT-1 → retry path.
  - Loss of lock → retry path.
- S_RUN:
  - Entering S_RUN clears retry_cnt_o.
  - Loss of lock → S_PULSE on the next edge with retry_cnt_o unchanged. This asserts all three resets in that same cycle.
  - Calib_done falling in S_RUN is ignored.
- Retry path:
  - If retry_cnt_o==MAX_RETRIES → S_FAIL.
  - Otherwise retry_cnt_o+1 and go to S_PULSE.
  - retry_cnt_o never exceeds MAX_RETRIES.
- S_FAIL: absorbing state; leaves only via wb_rst_i.
- Simultaneous events:
  - In S_CALIB, lock loss takes priority over calib_done.
  - In S_LOCK, lock wins over timeout in the same cycle.
- Counter saturates and never wraps. The counter width is checked at elaboration: a parameter exceeding 2^CNT_W-1 is a fatal error.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, CALIB_TIMEOUT=64, MAX_RETRIES=2. In scenarios 1-3 and 5, "cycles" count edges from the first edge after wb_rst_i falls.
1. Clean bring-up: locks and calib tied high before reset release.
   - pll_rst_o high exactly 4 cycles.
   - ddr2_rst_o falls at cycle 13.
   - wb_rst_o falls and ready_o rises at cycle 14.
   - retry_cnt_o=0.
2. Locks never assert → pulses of 4 cycles separated by 32 cycles of S_LOCK; retry_cnt_o steps 1, 2; third timeout gives fail_o=1, state_o=5, pll_rst_o=0, wb_rst_o=1; remains until wb_rst_i.
3. pll_locked_i glitches low for 1 cycle at S_STABLE cycle 5 → returns to S_LOCK; ddr2_rst_o stays 1; retry_cnt_o=0; S_STABLE then restarts a full 8 cycles.
4. calib_done held low → timeout after 64 cycles in S_CALIB; ddr2_rst_o re-asserts; retry_cnt_o=1; calib then raised on second attempt → ready_o=1, retry_cnt_o cleared to 0.
5. In S_RUN, dcm_locked_i falls → wb_rst_o and ddr2_rst_o high, ready_o low 3 cycles later (2 synchronizer + 1); full sequence reruns; retry_cnt_o stays 0.
6. wb_rst_i asserted for 1 cycle while in S_CALIB → all outputs return to reset values on the next edge, state_o=0, sequence restarts.
